// File: rtl/alu_issue_ctrl.sv
// Single-issue controller: accepts one 16-bit instruction, reads an 8x32 register
// file, drives an external combinational ALU, and writes the result back.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_ovf,
    output logic        done,
    output logic [31:0] wb_data,
    output logic        zero_out,
    output logic        ovf_out,
    output logic        illegal,
    output logic        ovf_sticky,
    input  logic [2:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_LI  = 3'b111;

    logic [1:0]  r_state;
    logic [15:0] r_instr;
    logic [31:0] r_rf [8];
    logic [31:0] r_res;
    logic        r_zero;
    logic        r_ovf;

    logic [2:0]  w_op;
    logic [2:0]  w_rd;
    logic [2:0]  w_rs;
    logic [2:0]  w_rt;
    logic [31:0] w_imm;
    logic        w_is_alu;
    logic        w_is_li;

    assign w_op  = r_instr[15:13];
    assign w_rd  = r_instr[12:10];
    assign w_rs  = r_instr[9:7];
    assign w_rt  = r_instr[6:4];
    assign w_imm = {22'b0, r_instr[9:0]};

    assign w_is_alu = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND) ||
                      (w_op == OP_OR)  || (w_op == OP_SLT);
    assign w_is_li  = (w_op == OP_LI);

    assign instr_ready = (r_state == S_IDLE);
    assign dbg_data    = (dbg_addr == 3'd0) ? 32'd0 : r_rf[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_instr    <= '0;
            r_res      <= '0;
            r_zero     <= 1'b0;
            r_ovf      <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            done       <= 1'b0;
            wb_data    <= '0;
            zero_out   <= 1'b0;
            ovf_out    <= 1'b0;
            illegal    <= 1'b0;
            ovf_sticky <= 1'b0;
            // NOTE: the register file is cleared by reset, so it must stay in flops rather than a RAM macro.
            for (int i = 0; i < 8; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_instr <= instr;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (w_is_alu) begin
                        alu_a    <= r_rf[w_rs];
                        alu_b    <= r_rf[w_rt];
                        alu_ctrl <= w_op;
                        r_state  <= S_EXEC;
                    end else begin
                        r_state  <= S_WB;
                    end
                end
                S_EXEC: begin
                    r_res   <= alu_result;
                    r_zero  <= alu_zero;
                    r_ovf   <= alu_ovf;
                    r_state <= S_WB;
                end
                S_WB: begin
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                    if (w_is_alu) begin
                        // Overflowing results are still committed; only the flags record it.
                        if (w_rd != 3'd0) r_rf[w_rd] <= r_res;
                        wb_data  <= r_res;
                        zero_out <= r_zero;
                        ovf_out  <= r_ovf;
                        illegal  <= 1'b0;
                        if (r_ovf) ovf_sticky <= 1'b1;
                    end else if (w_is_li) begin
                        if (w_rd != 3'd0) r_rf[w_rd] <= w_imm;
                        wb_data  <= w_imm;
                        zero_out <= (w_imm == 32'd0);
                        ovf_out  <= 1'b0;
                        illegal  <= 1'b0;
                    end else begin
                        wb_data  <= '0;
                        zero_out <= 1'b0;
                        ovf_out  <= 1'b0;
                        illegal  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock), rst input 1 (synchronous active-high reset).
REQ-002 The block SHALL expose these ports: instr_valid input 1, instruction offered; instr_ready output 1, block can accept; instr input 16, instruction word.
REQ-003 The block SHALL expose these ALU-facing ports: alu_a output 32, ALU operand A; alu_b output 32, ALU operand B; alu_ctrl output 3, ALU operation code.
REQ-004 The block SHALL expose these ALU-result ports: alu_result input 32, ALU result (combinational from alu_a/alu_b/alu_ctrl); alu_zero input 1, ALU zero flag; alu_ovf input 1, ALU overflow flag.
REQ-005 The block SHALL expose these completion ports: done output 1, one-cycle completion pulse; wb_data output 32, value written (or computed); zero_out output 1, captured zero flag; ovf_out output 1, captured overflow flag; illegal output 1, illegal opcode, valid with done.
REQ-006 The block SHALL expose these status and debug ports: ovf_sticky output 1, overflow seen since reset; dbg_addr input 3, debug read index; dbg_data output 32, combinational rf[dbg_addr].

Function
REQ-007 The instr fields SHALL be: [15:13] op, [12:10] rd, [9:7] rs, [6:4] rt; for LI, imm = instr[9:0].
REQ-008 The op encodings SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT (forwarded to alu_ctrl unchanged); 111 LI; 100 and 110 illegal.
REQ-009 The register file SHALL be 8 x 32; r0 reads as 0 and writes to r0 SHALL be discarded.
REQ-010 The FSM states SHALL be IDLE, READ, EXEC, WB; instr_ready=1 only in IDLE.
REQ-011 Accept: instr_valid && instr_ready at an edge latches instr and moves IDLE->READ; instr_valid while not ready SHALL be ignored (no queueing).
REQ-012 READ, ALU op: at the edge, alu_a<=rf[rs], alu_b<=rf[rt], alu_ctrl<=op; go to EXEC.
REQ-013 READ, LI or illegal: alu_a/alu_b/alu_ctrl SHALL hold; go directly to WB.
REQ-014 EXEC SHALL last exactly one cycle; at its closing edge, capture alu_result, alu_zero, alu_ovf into internal regs; go to WB.
REQ-015 WB, ALU op: rf[rd]<=captured result; wb_data=result; zero_out/ovf_out = captured flags; ovf_sticky set if captured ovf=1.
REQ-016 WB, LI: rf[rd]<={22'b0, imm}; wb_data = that value; zero_out=(value==0); ovf_out=0.
REQ-017 WB, illegal: no register write; wb_data=0; zero_out=0; ovf_out=0; illegal=1.
REQ-018 WB is registered so that done=1 for exactly the cycle after entering WB ends, together with wb_data/zero_out/ovf_out/illegal; the state then returns to IDLE and done deasserts next cycle.
REQ-019 Latency (accept edge = edge 0): an ALU op SHALL have done=1 in the cycle following edge 3; LI/illegal after edge 2.
REQ-020 An overflowing ALU result SHALL still be written; overflow SHALL NOT block write-back.
REQ-021 Back-to-back: a new instruction SHALL be acceptable on the first IDLE cycle, so a dependent read sees the prior write (no hazard logic needed).
REQ-022 wb_data/zero_out/ovf_out/illegal SHALL hold their last values while done=0.

Reset
REQ-023 While rst=1 at an edge: state<=IDLE; all rf entries<=0; alu_a, alu_b, wb_data <= 0; alu_ctrl<=000; done, zero_out, ovf_out, illegal, ovf_sticky <= 0.
REQ-024 Reset mid-operation SHALL abandon the instruction: no write-back and no done pulse; instr_ready=1 the cycle after rst deasserts.
REQ-025 ovf_sticky SHALL be cleared only by rst.

Verification
REQ-026 LI r1=0x234, LI r2=0x0FF, ADD r3=r1+r2 -> done after 3rd edge, wb_data=0x00000333, zero_out=0, dbg_addr=3 reads 0x333.
REQ-027 SUB r4=r1-r1 -> wb_data=0, zero_out=1, ovf_out=0; SLT r5=r2<r1 -> wb_data=1; SLT r5=r1<r2 -> wb_data=0.
REQ-028 Preload r6=0x7FFFFFFF via a model ALU/ADD chain, then ADD r7=r6+r(one) -> wb_data=0x80000000, ovf_out=1, ovf_sticky=1, which stays 1 over later ops until rst.
REQ-029 op=100 and op=110 -> done with illegal=1, wb_data=0, rf unchanged (check all 8 via dbg); LI r0=0x3FF -> dbg r0 reads 0.
REQ-030 Assert rst during EXEC of ADD r3 -> no done pulse, rf all 0, outputs 0, instr_ready=1 next cycle; instr_valid held during READ/EXEC/WB -> not re-accepted until IDLE.
